// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/and/or/shl plus a fixed-length
// iterative shift-add multiplier, behind a start/busy/done handshake.
module alu_exec_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic [0:0]        fsm_state
);

  // Handshake: a request is accepted at a rising edge where start=1 and
  // busy=0; done pulses for one cycle when result/zero have been updated.

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [0:0]        state;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplr;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] single_res;
  logic [DATA_W-1:0] acc_next;

  // Illegal codes fall into the default arm and produce zero.
  always_comb begin
    single_res = '0;
    case (alu_ctrl)
      OP_ADD:  single_res = src_a + src_b;
      OP_SUB:  single_res = src_a - src_b;
      OP_AND:  single_res = src_a & src_b;
      OP_OR:   single_res = src_a | src_b;
      OP_SHL:  single_res = src_a << src_b[CNT_W-1:0];
      default: single_res = '0;
    endcase
  end

  always_comb begin
    acc_next = acc;
    if (mplr[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      mcand  <= '0;
      mplr   <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (alu_ctrl == OP_MUL) begin
              mcand <= src_a;
              mplr  <= src_b;
              acc   <= '0;
              cnt   <= '0;
              state <= ST_MUL;
            end else begin
              result <= single_res;
              zero   <= (single_res == '0);
              done   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          // Always runs all DATA_W iterations so the stall length is fixed.
          acc   <= acc_next;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            result <= acc_next;
            zero   <= (acc_next == '0);
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_MUL);
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected {result,zero} and the cycle at
// which done must appear are queued at issue time and checked by a monitor.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  alu_ctrl;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        zero;
  logic [0:0]  fsm_state;

  logic [16:0] exp_q[$];
  int          cyc_q[$];
  int          cyc;
  int          compared;
  int          mismatched;

  alu_exec_unit #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .fsm_state (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [16:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("result", 32'(result), 32'(e[16:1]));
        chk("zero", 32'(zero), 32'(e[0]));
        chk("done_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input bit push);
    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    if (push) begin
      exp_q.push_back({er, (er == 16'h0000)});
      cyc_q.push_back(cyc + ((c == 3'b101) ? 17 : 1));
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input bit mid_start);
    issue(3'b101, a, b, er, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        src_a = ~a;
        src_b = ~b;
      end
      chk("mul_busy", 32'(busy), 32'd1);
      if (mid_start && i == 5) begin
        start    = 1'b1;
        alu_ctrl = 3'b000;
      end
      if (mid_start && i == 6) start = 1'b0;
    end
    @(negedge clk);
    chk("mul_busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    start      = 1'b0;
    alu_ctrl   = 3'b000;
    src_a      = 16'h0000;
    src_b      = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'h0000);
    chk("rst_zero", 32'(zero), 32'd1);
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // back-to-back single-cycle ops
    issue(3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    issue(3'b001, 16'h0005, 16'h0007, 16'hFFFE, 1'b1);
    issue(3'b100, 16'h0003, 16'h0012, 16'h000C, 1'b1);
    issue(3'b011, 16'h1200, 16'h0034, 16'h1234, 1'b1);
    issue(3'b001, 16'h0005, 16'h0005, 16'h0000, 1'b1);
    release_start();

    run_mul(16'h0123, 16'h0045, 16'h4E6F, 1'b1);
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);
    run_mul(16'h1234, 16'h0000, 16'h0000, 1'b0);
    // start held through the done cycle is accepted immediately
    issue(3'b101, 16'h0003, 16'h0007, 16'h0015, 1'b1);
    repeat (16) @(negedge clk);
    issue(3'b010, 16'hFF00, 16'h0F0F, 16'h0F00, 1'b1);
    release_start();

    // reset in the middle of a multiply: aborted, no done
    issue(3'b101, 16'h00FF, 16'h00FF, 16'h0000, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'h0000);
    chk("abort_zero", 32'(zero), 32'd1);
    issue(3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b1);
    release_start();
    src_a = 16'hAAAA;
    src_b = 16'h5555;
    repeat (3) @(negedge clk);
    chk("result_hold", 32'(result), 32'h00F0);

    // illegal codes
    issue(3'b110, 16'h1234, 16'h5678, 16'h0000, 1'b1);
    issue(3'b111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1);
    release_start();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
